// File: rtl/lif_array.sv
// lif_array: bank of leaky integrate-and-fire neurons sharing one threshold.
// Each channel integrates its current once per enabled step, saturates the
// membrane at 2^WIDTH-1 and emits a registered one-cycle spike.
// Optional feature macro: LIF_RESET_SUBTRACT_EN selects reset-by-subtraction
// (post-spike state = v - threshold); undefined resets the membrane to zero.
module lif_array #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned LEAK_SHIFT     = 1,
  parameter int unsigned THRESH_INIT    = 127,
  parameter int unsigned REFRACT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] current,
  input  logic                      thr_load,
  input  logic [WIDTH-1:0]          thr_in,
  output logic [WIDTH-1:0]          threshold,
  output logic [CHANNELS*WIDTH-1:0] state,
  output logic [CHANNELS-1:0]       spike,
  output logic [CHANNELS-1:0]       refractory
);

  // Counter is kept one bit wide when the refractory period is disabled.
  localparam int unsigned CntW = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

  logic [CHANNELS*WIDTH-1:0] state_q, state_d;
  logic [CHANNELS-1:0]       spike_q, spike_d;
  logic [WIDTH-1:0]          thr_q, thr_d;
  logic [CntW-1:0]           cnt_q [CHANNELS];
  logic [CntW-1:0]           cnt_d [CHANNELS];
  logic [WIDTH:0]            sum   [CHANNELS];
  logic [WIDTH-1:0]          v     [CHANNELS];

  // Next-state: integrate, leak, saturate and fire each channel independently.
  always_comb begin
    state_d = state_q;
    spike_d = '0;
    cnt_d   = cnt_q;
    thr_d   = thr_load ? thr_in : thr_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sum[i] = {1'b0, current[i*WIDTH +: WIDTH]} +
               {1'b0, (state_q[i*WIDTH +: WIDTH] >> LEAK_SHIFT)};
      v[i]   = sum[i][WIDTH] ? '1 : sum[i][WIDTH-1:0];
      if (en) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - CntW'(1);
        end else if (v[i] >= thr_q) begin
          spike_d[i] = 1'b1;
          cnt_d[i]   = CntW'(REFRACT_CYCLES);
`ifdef LIF_RESET_SUBTRACT_EN
          state_d[i*WIDTH +: WIDTH] = v[i] - thr_q;
`else
          state_d[i*WIDTH +: WIDTH] = '0;
`endif
        end else begin
          state_d[i*WIDTH +: WIDTH] = v[i];
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= '0;
      spike_q <= '0;
      thr_q   <= WIDTH'(THRESH_INIT);
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      spike_q <= spike_d;
      thr_q   <= thr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Refractory flag is simply "counter non-zero".
  always_comb begin
    refractory = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      refractory[i] = (cnt_q[i] != '0);
    end
  end

  assign threshold = thr_q;
  assign state     = state_q;
  assign spike     = spike_q;

endmodule

// File: tb/tb_lif_array.sv
// Bench for lif_array: two instances (no refractory, REFRACT_CYCLES=2) share
// all inputs and are compared every step against an arithmetic model.
module tb_lif_array;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] current;
  logic        thr_load;
  logic [7:0]  thr_in;
  logic [7:0]  thr_a, thr_b;
  logic [31:0] state_a, state_b;
  logic [3:0]  spike_a, spike_b, refr_a, refr_b;

  int n_cmp = 0;
  int n_err = 0;

  // Model state per instance (d) and channel (ch).
  int m_st  [2][4];
  int m_cnt [2][4];
  int m_spk [2][4];
  int m_thr [2];

  lif_array #(.WIDTH(8), .CHANNELS(4), .LEAK_SHIFT(1), .THRESH_INIT(127),
              .REFRACT_CYCLES(0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .current(current), .thr_load(thr_load),
    .thr_in(thr_in), .threshold(thr_a), .state(state_a), .spike(spike_a),
    .refractory(refr_a)
  );

  lif_array #(.WIDTH(8), .CHANNELS(4), .LEAK_SHIFT(1), .THRESH_INIT(127),
              .REFRACT_CYCLES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .current(current), .thr_load(thr_load),
    .thr_in(thr_in), .threshold(thr_b), .state(state_b), .spike(spike_b),
    .refractory(refr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_thr[d] = 127;
      for (int ch = 0; ch < 4; ch++) begin
        m_st[d][ch] = 0; m_cnt[d][ch] = 0; m_spk[d][ch] = 0;
      end
    end
  endtask

  task automatic model_step(input bit e, input bit tl, input int ti, input logic [31:0] cur);
    int v, r;
    for (int d = 0; d < 2; d++) begin
      r = (d == 0) ? 0 : 2;
      for (int ch = 0; ch < 4; ch++) begin
        m_spk[d][ch] = 0;
        if (!e) continue;
        if (m_cnt[d][ch] > 0) begin
          m_cnt[d][ch] = m_cnt[d][ch] - 1;
        end else begin
          v = int'(cur[ch*8 +: 8]) + m_st[d][ch] / 2;
          if (v > 255) v = 255;
          if (v >= m_thr[d]) begin
            m_spk[d][ch] = 1;
            m_cnt[d][ch] = r;
`ifdef LIF_RESET_SUBTRACT_EN
            m_st[d][ch] = v - m_thr[d];
`else
            m_st[d][ch] = 0;
`endif
          end else begin
            m_st[d][ch] = v;
          end
        end
      end
      if (tl) m_thr[d] = ti;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("thr[%0d]", d), (d == 0) ? int'(thr_a) : int'(thr_b), m_thr[d]);
      for (int ch = 0; ch < 4; ch++) begin
        chk($sformatf("state[%0d][%0d]", d, ch),
            (d == 0) ? int'(state_a[ch*8 +: 8]) : int'(state_b[ch*8 +: 8]), m_st[d][ch]);
        chk($sformatf("spike[%0d][%0d]", d, ch),
            (d == 0) ? int'(spike_a[ch]) : int'(spike_b[ch]), m_spk[d][ch]);
        chk($sformatf("refr[%0d][%0d]", d, ch),
            (d == 0) ? int'(refr_a[ch]) : int'(refr_b[ch]), (m_cnt[d][ch] > 0) ? 1 : 0);
      end
    end
  endtask

  // Called one time unit after a rising edge; drives, clocks, then checks.
  task automatic do_step(input bit e, input bit tl, input int ti, input logic [31:0] cur);
    rst_n = 1'b1; en = e; thr_load = tl; thr_in = 8'(ti); current = cur;
    @(posedge clk);
    model_step(e, tl, ti, cur);
    #1;
    check_all();
  endtask

  task automatic do_reset(input bit e, input bit tl);
    rst_n = 1'b0; en = e; thr_load = tl; thr_in = 8'd5; current = 32'hFFFF_FFFF;
    @(posedge clk);
    model_reset();
    #1;
    check_all();
    chk("reset_thr", int'(thr_a), 127);
    chk("reset_state", int'(state_b), 0);
    chk("reset_spike", int'({spike_a, spike_b}), 0);
  endtask

  typedef struct {
    logic [7:0] cur;
    int         exp_state;
    int         exp_spike;
  } vec_t;

  vec_t integ [7];
  int   e_st1, e_st2, e_sr;
  logic [31:0] cur_r;
  int   ti_r;

  initial begin
    integ[0] = '{8'd64, 64, 0};
    integ[1] = '{8'd64, 96, 0};
    integ[2] = '{8'd64, 112, 0};
    integ[3] = '{8'd64, 120, 0};
    integ[4] = '{8'd64, 124, 0};
    integ[5] = '{8'd64, 126, 0};
    integ[6] = '{8'd64, 0, 1};
`ifdef LIF_RESET_SUBTRACT_EN
    e_st1 = 73; e_st2 = 109; e_sr = 128;
`else
    e_st1 = 0;  e_st2 = 0;   e_sr = 0;
`endif

    rst_n = 1'b0; en = 1'b0; thr_load = 1'b0; thr_in = '0; current = '0;
    @(posedge clk);
    #1;
    do_reset(1'b1, 1'b1);

    // Integration toward threshold on channel 0.
    for (int k = 0; k < 7; k++) begin
      do_step(1'b1, 1'b0, 0, {24'd0, integ[k].cur});
      chk($sformatf("integ_state[%0d]", k), int'(state_a[7:0]), integ[k].exp_state);
      chk($sformatf("integ_spike[%0d]", k), int'(spike_a[0]), integ[k].exp_spike);
    end
    do_step(1'b1, 1'b0, 0, 32'd64);
    chk("integ_spike_one_cycle", int'(spike_a[0]), 0);

    // Saturation against threshold 255.
    do_reset(1'b0, 1'b0);
    do_step(1'b0, 1'b1, 255, 32'd0);
    do_step(1'b1, 1'b0, 0, 32'd200);
    chk("sat_state1", int'(state_a[7:0]), 200);
    chk("sat_spike1", int'(spike_a[0]), 0);
    do_step(1'b1, 1'b0, 0, 32'd200);
    chk("sat_spike2", int'(spike_a[0]), 1);
    chk("sat_state2", int'(state_a[7:0]), 0);

    // Refractory period of 2 on instance b.
    do_reset(1'b0, 1'b0);
    do_step(1'b1, 1'b0, 0, 32'd255);
    chk("refr_spike1", int'(spike_b[0]), 1);
    chk("refr_flag1", int'(refr_b[0]), 1);
    do_step(1'b1, 1'b0, 0, 32'd255);
    chk("refr_spike2", int'(spike_b[0]), 0);
    chk("refr_state2", int'(state_b[7:0]), e_sr);
    chk("refr_flag2", int'(refr_b[0]), 1);
    do_step(1'b1, 1'b0, 0, 32'd255);
    chk("refr_spike3", int'(spike_b[0]), 0);
    chk("refr_flag3", int'(refr_b[0]), 0);
    do_step(1'b1, 1'b0, 0, 32'd255);
    chk("refr_spike4", int'(spike_b[0]), 1);

    // Post-spike residual (subtract vs zero).
    do_reset(1'b0, 1'b0);
    do_step(1'b1, 1'b0, 0, 32'd200);
    chk("sub_spike1", int'(spike_a[0]), 1);
    chk("sub_state1", int'(state_a[7:0]), e_st1);
    do_step(1'b1, 1'b0, 0, 32'd200);
    chk("sub_spike2", int'(spike_a[0]), 1);
    chk("sub_state2", int'(state_a[7:0]), e_st2);

    // Enable gating across four channels, then coincident threshold load.
    do_reset(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      do_step((k % 3) != 2, 1'b0, 0, {8'd255, 8'd128, 8'd64, 8'd0});
    end
    do_reset(1'b0, 1'b0);
    do_step(1'b1, 1'b1, 0, {8'd0, 8'd0, 8'd64, 8'd0});
    chk("thr_old_used", int'(spike_a[1]), 0);
    do_step(1'b1, 1'b0, 0, {8'd0, 8'd0, 8'd0, 8'd0});
    chk("thr_zero_spikes", int'(spike_a), 15);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cur_r = $urandom;
      case ($urandom_range(0, 3))
        0: ti_r = 0;
        1: ti_r = 255;
        default: ti_r = int'($urandom_range(0, 255));
      endcase
      do_step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, ti_r, cur_r);
    end

    // Reset while enabled with nonzero state.
    do_step(1'b1, 1'b1, 200, 32'h4040_4040);
    do_step(1'b1, 1'b0, 0, 32'h4040_4040);
    do_reset(1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lif_array.md
# lif_array

Parameterised bank of leaky integrate-and-fire neurons, the multi-channel successor to the single 8-bit LIF cell. It adds configurable width, leak, refractory period and a runtime-loadable threshold. Each channel integrates its own input current once per enabled time step and emits a registered one-cycle spike. It sits between the input current/synapse stage and the winner-take-all / spike-routing logic.

## Interface
- `WIDTH`, 8: membrane, current and threshold width in bits.
- `CHANNELS`, 4: number of independent neurons.
- `LEAK_SHIFT`, 1: leak as a right shift of the membrane; 1 means beta = 0.5.
- `THRESH_INIT`, 127: threshold value after reset.
- `REFRACT_CYCLES`, 0: enabled steps a channel ignores input after spiking; 0 disables the refractory period.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: time-step strobe; state advances only on edges where `en` = 1.
- `current` in CHANNELS*WIDTH: unsigned input current. Channel i is at `[i*WIDTH +: WIDTH]`.
- `thr_load` in 1: load `thr_in` into the shared threshold register.
- `thr_in` in WIDTH: new threshold value.
- `threshold` out WIDTH: current threshold register.
- `state` out CHANNELS*WIDTH: registered membrane potentials, same packing as `current`.
- `spike` out CHANNELS: registered spike flags.
- `refractory` out CHANNELS: 1 while a channel's refractory counter is non-zero.

## Operation
- Reset values: all `state` = 0; all refractory counters = 0; `refractory` = 0; `spike` = 0; `threshold` = THRESH_INIT.
- Per channel i, on each edge with `en` = 1 and `rst_n` = 1:
  - If channel i is refractory (counter > 0): decrement the counter, hold `state[i]`, clear `spike[i]`, and ignore `current[i]`.
  - Otherwise, compute v = current[i] + (state[i] >> LEAK_SHIFT) at WIDTH+1 bits, then saturate to 2^WIDTH − 1.
    - If v >= threshold: set `spike[i]` = 1, load `state[i]` with the post-spike value (see Configuration), and load the counter with REFRACT_CYCLES.
    - Else: `state[i]` = v and `spike[i]` = 0.
- On edges with `en` = 0: all `state` values and counters hold, and every `spike` bit is cleared to 0.
- Channels are fully independent. The only thing they share is the threshold.
- Threshold register:
  - `thr_load` = 1 loads `thr_in` on that edge, regardless of `en`.
  - A step taken on the same edge compares against the old threshold.
- Threshold = 0: every non-refractory step spikes.
- Threshold = 2^WIDTH − 1: a channel spikes only on a saturated v.
- Reset mid-step overrides `en` and `thr_load` entirely.

## Timing
- Latency: `spike` and `state` reflect step k one cycle after the `en` edge of step k.
- `spike` is high for exactly one cycle per step and is never held across steps.
- Back-to-back `en` (every cycle) is fully supported; there is no throughput limit.
- Refractory: after a spike, the channel skips exactly REFRACT_CYCLES enabled steps. The earliest next spike is on enabled step REFRACT_CYCLES + 1 after the spiking step.
- `refractory[i]` rises on the spike edge when REFRACT_CYCLES > 0. It falls on the edge where the counter reaches 0.

## Configuration
- Macro: `LIF_RESET_SUBTRACT_EN`.
- Defined: the post-spike state is v − threshold (reset by subtraction), so residual charge carries over.
- Undefined: the post-spike state is 0 (reset to zero).
- All other behaviour is identical in both builds.

## Test plan
All scenarios use WIDTH=8, LEAK_SHIFT=1, THRESH_INIT=127 and `en` held high unless stated.
- **Integration:** CHANNELS=1, REFRACT_CYCLES=0, current=64.
  - Required `state` sequence: 64, 96, 112, 120, 124, 126.
  - On step 7 (v=127), `spike` = 1 for one cycle and `state` = 0 (both builds).
- **Saturation:** load thr_in=255, then current=200.
  - Step 1: `state` = 200, no spike.
  - Step 2: v = 300 saturates to 255 and `spike` = 1.
  - Post-spike `state` = 0 (subtract build: 255 − 255 = 0).
- **Refractory:** REFRACT_CYCLES=2, current=255.
  - Spikes on steps 1 and 4 only.
  - Steps 2–3: `refractory` = 1, `state` = 0, input ignored.
- **Subtract build:** `LIF_RESET_SUBTRACT_EN` defined, current=200, thr=127.
  - Step 1: spike, `state` = 73.
  - Step 2: v = 236, spike, `state` = 109.
- **Enable gating and independence:** CHANNELS=4 with currents 0/64/128/255.
  - Toggling `en` freezes `state` and clears `spike` while low.
  - Each channel matches its own single-channel model.
  - `thr_load` coincident with a step uses the old threshold.
- **Reset mid-operation:** assert `rst_n` = 0 with `en` = 1 and nonzero state.
  - Next cycle: all outputs are at their reset values and `threshold` = 127.
